// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a power-of-two byte FIFO.
// Frames leave back-to-back while the FIFO holds data; uart_tx is driven straight from a flop.
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES = 234,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmrW = ($clog2(DELAY_FRAMES) > 13) ? $clog2(DELAY_FRAMES) : 13;
  localparam logic [TmrW-1:0] TmrLast   = TmrW'(DELAY_FRAMES - 1);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [TmrW-1:0] timer_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  state_e          state_q;

  logic push, pop, bit_end;

  assign in_ready = (count_q < FullCount);
  assign push     = in_valid && in_ready;
  assign bit_end  = (timer_q == TmrLast);
  // Pop either from idle or exactly at the end of a stop bit, so frames abut.
  assign pop      = (count_q != '0) &&
                    ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  assign uart_tx    = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            tx_q      <= 1'b0;
            bit_idx_q <= '0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            timer_q <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            timer_q <= '0;
            if (pop) begin
              shift_q   <= mem_q[rd_ptr_q];
              tx_q      <= 1'b0;
              bit_idx_q <= '0;
              state_q   <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line-level receiver model pops expected bytes from a scoreboard
// queue and checks every cycle of each frame; directed cases cover latency, FIFO and reset.
module tb_uart_tx_fifo;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, uart_tx, busy;
  logic [2:0] fifo_count;

  logic [7:0] in_data2 = 8'h00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, uart_tx2, busy2;
  logic [3:0] fifo_count2;

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  uart_tx_fifo dut_default (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data2),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .uart_tx    (uart_tx2),
    .busy       (busy2),
    .fifo_count (fifo_count2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int n_acc = 0;
  int n_started = 0;
  bit cnt_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Drive a byte from just after a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [7:0] b, input int maxwait, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    in_data = b;
    in_valid = 1'b1;
    for (int w = 0; w < maxwait && !done; w++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(b);
        n_acc++;
        acc = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    check($sformatf("send_accepted_%02h", b), int'(done), 1);
  endtask

  task automatic drain(input int limit);
    int w;
    w = 0;
    while (busy && w < limit) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain_busy_low", int'(busy), 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Receiver model: expected frame is start 0, data LSB first, stop 1, each bit D cycles.
  initial begin : monitor
    logic [9:0] frame;
    logic [7:0] b;
    bit have, ok, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        starts.push_back(cyc);
        n_started++;
        have = (exp_q.size() > 0);
        b = 8'h00;
        if (have) b = exp_q.pop_front();
        frame = {1'b1, b, 1'b0};
        ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < int'(FRAME); k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (cnt_en) check("fifo_count_model", int'(fifo_count), n_acc - n_started);
          if (uart_tx !== frame[k / int'(D)]) ok = 1'b0;
        end
        if (!aborted) begin
          check("frame_expected", int'(have), 1);
          if (have) check($sformatf("frame_bits_%02h", b), int'(ok), 1);
        end
      end else if (cnt_en && rst_n) begin
        check("fifo_count_model", int'(fifo_count), n_acc - n_started);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc, acc1, acc6, nfr, lows, w;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte and idle latency
    send(8'h55, 5, acc);
    in_valid = 1'b0;
    check("lat_count_after_push", int'(fifo_count), 1);
    check("lat_tx_still_high", int'(uart_tx), 1);
    check("lat_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_tx_low_next_edge", int'(uart_tx), 0);
    check("lat_count_popped", int'(fifo_count), 0);
    drain(100);
    check("single_start_edge", starts[$], acc + 1);

    // Back-to-back frames
    send(8'hA3, 5, acc);
    send(8'h0F, 5, acc);
    in_valid = 1'b0;
    drain(200);
    check("b2b_gap", starts[$] - starts[$-1], int'(FRAME));

    // Full FIFO with in_valid held high
    send(8'h31, 5, acc1);
    for (int i = 2; i <= 5; i++) send(8'h30 + 8'(i), 5, acc);
    check("full_count", int'(fifo_count), int'(DEPTH));
    check("full_in_ready", int'(in_ready), 0);
    send(8'h36, 100, acc6);
    in_valid = 1'b0;
    check("full_sixth_accept_edge", acc6, acc1 + 42);
    drain(400);

    // Push on the edge of the stop-end pop
    send(8'hC1, 5, acc1);
    send(8'hC2, 5, acc);
    send(8'hC3, 5, acc);
    in_valid = 1'b0;
    check("simul_count_before", int'(fifo_count), 2);
    while (cyc < acc1 + int'(FRAME)) @(negedge clk);
    send(8'hC4, 1, acc);
    in_valid = 1'b0;
    check("simul_accept_edge", acc, acc1 + 41);
    check("simul_count_after", int'(fifo_count), 2);
    check("simul_new_frame_low", int'(uart_tx), 0);
    drain(400);

    // Reset during data bit 3 of 0xFF with more bytes queued
    send(8'hFF, 5, acc1);
    send(8'h11, 5, acc);
    send(8'h22, 5, acc);
    in_valid = 1'b0;
    while (cyc < acc1 + 18) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_uart_tx", int'(uart_tx), 1);
    check("midrst_fifo_count", int'(fifo_count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_tx_idle", int'(uart_tx), 1);
    check("postrst_busy", int'(busy), 0);
    nfr = starts.size();
    send(8'h81, 5, acc);
    in_valid = 1'b0;
    drain(200);
    check("postrst_one_frame", starts.size() - nfr, 1);

    // Randomized traffic with occupancy model
    n_acc = 0;
    n_started = 0;
    cnt_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
      if (w > 0) begin
        in_valid = 1'b0;
        repeat (w) @(negedge clk);
      end
      rb = 8'($urandom_range(0, 255));
      send(rb, 400, acc);
    end
    in_valid = 1'b0;
    drain(2000);
    cnt_en = 1'b0;

    // Default parameters: 0x00 keeps the line low for start + 8 bits
    check("def_in_ready", int'(in_ready2), 1);
    in_data2 = 8'h00;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    check("def_count_after_push", int'(fifo_count2), 1);
    w = 0;
    while (uart_tx2 && w < 5) begin
      @(negedge clk);
      w++;
    end
    lows = 0;
    while (!uart_tx2 && lows < 3000) begin
      lows++;
      @(negedge clk);
    end
    check("def_low_cycles", lows, 2106);
    w = 0;
    while (busy2 && w < 300) begin
      check("def_stop_high", int'(uart_tx2), 1);
      @(negedge clk);
      w++;
    end
    check("def_busy_drops", int'(busy2), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DELAY_FRAMES, default 234: clock cycles per UART bit (27 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 8: byte FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  8  byte to transmit.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 uart_tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO, excluding the byte being shifted.

Function
REQ-011 A push SHALL occur on a rising edge where in_valid and in_ready are both high; no other condition writes the FIFO.
REQ-012 in_ready SHALL be high exactly when fifo_count < FIFO_DEPTH, derived combinationally from the registered count.
REQ-013 in_valid with in_ready low SHALL be ignored, with no state change and no error flag.
REQ-014 FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-015 A simultaneous push and pop SHALL leave fifo_count unchanged and keep both bytes in order.
REQ-016 The transmitter FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-017 In IDLE with fifo_count > 0, the block SHALL pop the head into an 8-bit shift register, drive uart_tx low, clear the bit counter, and enter START on that edge.
REQ-018 START SHALL hold uart_tx = 0 for exactly DELAY_FRAMES cycles, then enter DATA.
REQ-019 DATA SHALL send bits LSB first, each held exactly DELAY_FRAMES cycles, using a 3-bit bit index.
REQ-020 After bit 7 completes, DATA SHALL enter STOP.
REQ-021 STOP SHALL hold uart_tx = 1 for exactly DELAY_FRAMES cycles.
REQ-022 At the end of STOP with fifo_count > 0, the block SHALL pop and enter START directly, with no idle cycle, so frames are back-to-back.
REQ-023 At the end of STOP with fifo_count = 0, the block SHALL enter IDLE.
REQ-024 Each frame SHALL occupy exactly 10*DELAY_FRAMES cycles of uart_tx.
REQ-025 The bit-timing counter SHALL be wide enough for DELAY_FRAMES (13 bits minimum) and SHALL reload at every bit boundary.
REQ-026 Latency: with the block idle and the FIFO empty, a byte pushed on edge N SHALL make uart_tx fall on edge N+1.
REQ-027 A byte pushed on edge N SHALL be reflected in fifo_count after edge N.
REQ-028 A byte pushed during a frame SHALL NOT alter the frame in progress.
REQ-029 busy SHALL be low only when the state is IDLE and fifo_count = 0.
REQ-030 uart_tx SHALL come directly from a flop, with no combinational path from inputs.

Reset
REQ-031 While rst_n = 0, outputs SHALL be: uart_tx = 1, busy = 0, fifo_count = 0, in_ready = 1.
REQ-032 While rst_n = 0, state SHALL be IDLE, and the pointers, bit counter and timing counter SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL force uart_tx high immediately (asynchronously), abort the frame and discard all FIFO contents.
REQ-034 After rst_n rises, the first rising edge SHALL behave as IDLE with an empty FIFO; no partial frame is ever resumed.

Verification (DELAY_FRAMES = 4, FIFO_DEPTH = 4 unless stated)
REQ-035 Single byte: push 0x55 while idle. Required: uart_tx low on the next edge, then bits 1,0,1,0,1,0,1,0, then high; 40 cycles total; busy drops afterwards.
REQ-036 Back-to-back: push 0xA3 and 0x0F on consecutive cycles. Required: two contiguous 40-cycle frames with no idle gap; LSB-first bit patterns 1,1,0,0,0,1,0,1 and 1,1,1,1,0,0,0,0.
REQ-037 Full FIFO: push 6 bytes with in_valid held high. Required:
- 1st byte popped immediately; next 4 accepted, fifo_count = 4, in_ready = 0.
- 6th byte stalls until the 2nd frame starts, then is accepted.
- All 6 bytes are transmitted in order.
REQ-038 Simultaneous push/pop: with fifo_count = 2, push on the edge where the STOP-end pop occurs. Required: fifo_count stays 2 and order is preserved.
REQ-039 Reset mid-frame: assert rst_n low during bit 3 of 0xFF. Required:
- uart_tx = 1 within the same cycle, fifo_count = 0, busy = 0.
- After release, a push of 0x81 yields one clean 40-cycle frame.
REQ-040 Default timing: DELAY_FRAMES = 234, push 0x00. Required: start plus 8 data bits low for 2106 cycles, then high.
